// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and helpers for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned BURST_W  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Index following i in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 32'd1 >= n) ? 32'd0 : i + 32'd1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side handshake plus register-file write port of the arbiter.
interface regfile_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 2
);
  logic                      Stall;
  logic [NUM_REQ-1:0]        ReqValid;
  logic [NUM_REQ-1:0]        ReqLock;
  logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
  logic [NUM_REQ*DATA_W-1:0] ReqData;
  logic [NUM_REQ-1:0]        ReqReady;
  logic                      RegWrite;
  logic [ADDR_W-1:0]         RD;
  logic [DATA_W-1:0]         WriteData;
  logic [1:0]                Owner;

  modport master (
    output Stall, ReqValid, ReqLock, ReqAddr, ReqData,
    input  ReqReady, RegWrite, RD, WriteData, Owner
  );

  modport slave (
    input  Stall, ReqValid, ReqLock, ReqAddr, ReqData,
    output ReqReady, RegWrite, RD, WriteData, Owner
  );
endinterface

// File: rtl/regfile_write_arbiter_picker.sv
// Round-robin picker: first valid requester at or after ptr, wrapping to 0.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] idx_c
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic        found;
  int unsigned j;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    j       = 32'd0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && valid[IDX_W'(j)]) begin
        found                = 1'b1;
        grant_c[IDX_W'(j)]   = 1'b1;
        idx_c                = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter with locked bursts and a registered register-file write stage.
// Optional per-requester grant counters on output GrantCount when RFA_STATS_EN is defined.
module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned DATA_W    = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W    = regfile_pkg::ADDR_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  regfile_write_arbiter_if.slave bus
`ifdef RFA_STATS_EN
  , output logic [NUM_REQ*regfile_pkg::CNT_W-1:0] GrantCount
`endif
);
  import regfile_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic [NUM_REQ-1:0] pick_grant_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic [NUM_REQ-1:0] ready_c;
  logic [IDX_W-1:0]   gnt_idx_c;
  logic               xfer_c;

  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;

  assign req_addr = bus.ReqAddr;
  assign req_data = bus.ReqData;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid   (bus.ReqValid),
    .ptr     (ptr_q),
    .grant_c (pick_grant_c),
    .idx_c   (pick_idx_c)
  );

  // State register together with the arbitration bookkeeping and output stage.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      burst_q    <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  // Grant generation; ready is only ever raised towards a valid requester.
  always_comb begin
    ready_c   = '0;
    gnt_idx_c = pick_idx_c;
    if (Reset_n && !bus.Stall) begin
      unique case (state_q)
        IDLE:   ready_c = pick_grant_c;
        LOCKED: begin
          gnt_idx_c = owner_q;
          if (bus.ReqValid[owner_q]) ready_c[owner_q] = 1'b1;
        end
        default: ready_c = '0;
      endcase
    end
  end

  assign xfer_c = |ready_c;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    burst_d    = burst_q;
    regwrite_d = xfer_c;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    if (xfer_c) begin
      owner_d = gnt_idx_c;
      rd_d    = req_addr[gnt_idx_c];
      wdata_d = req_data[gnt_idx_c];
    end
    if (!bus.Stall) begin
      unique case (state_q)
        IDLE: begin
          if (xfer_c) begin
            if (bus.ReqLock[gnt_idx_c] && (MAX_BURST > 32'd1)) begin
              state_d = LOCKED;
              burst_d = BURST_W'(1);
            end else begin
              ptr_d = IDX_W'(wrap_inc(32'(gnt_idx_c), NUM_REQ));
            end
          end
        end
        LOCKED: begin
          // Owner dropping valid releases the lock without a grant this cycle.
          if (xfer_c) begin
            burst_d = burst_q + BURST_W'(1);
            if (!bus.ReqLock[owner_q] || (32'(burst_q) + 32'd1 >= MAX_BURST)) begin
              state_d = IDLE;
              ptr_d   = IDX_W'(wrap_inc(32'(owner_q), NUM_REQ));
            end
          end else begin
            state_d = IDLE;
            ptr_d   = IDX_W'(wrap_inc(32'(owner_q), NUM_REQ));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.ReqReady  = ready_c;
  assign bus.RegWrite  = regwrite_q;
  assign bus.RD        = rd_q;
  assign bus.WriteData = wdata_q;
  assign bus.Owner     = 2'(owner_q);

`ifdef RFA_STATS_EN
  // Saturating accepted-beat counters, one per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (ready_c[g] && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign GrantCount[g*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule
